// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory read by the fetch stage.
//
// A host streams bytes over a valid/ready link. Each session carries:
//   * a little-endian word-count header (2 bytes),
//   * that many little-endian 32-bit words, written to RAM from word 0 upward.
// A synchronous word-addressed read port supplies fetch with the instruction word.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): one trailing byte follows the
// payload. It must equal the XOR of all payload bytes, or err is set.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   load_start        one-cycle request to open a session (ignored while busy)
//   in_valid/in_data  stream byte from the host
//   in_ready          loader accepts the byte this cycle
//   busy              a session is in progress
//   done              one-cycle pulse at the end of a session
//   err               sticky: overflow or checksum mismatch, cleared by the next session
//   words_loaded      words written in the last or current session
//   rd_addr           fetch byte address; bits [1:0] and the upper bits are ignored
//   rd_data           registered instruction word, forced to 0 while busy
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_loaded,
  input  logic [31:0]       rd_addr,
  output logic [31:0]       rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] WptrOne = 1;
  localparam logic [LEN_W-1:0] LenOne = 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StChk, StDone} state_e;
  localparam state_e StEnd = StChk;
`else
  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StDone} state_e;
  localparam state_e StEnd = StDone;
`endif

  state_e             state_q;
  logic [7:0]         len_lo_q;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         byte_cnt_q;
  logic [23:0]        word_buf_q;
  // One extra bit so the pointer can sit at Depth once the RAM is full.
  logic [ADDR_W:0]    wptr_q;
  logic [LEN_W-1:0]   word_cnt_q;
  logic [LEN_W-1:0]   words_loaded_q;
  logic               err_q;
  logic [31:0]        rd_data_q;
  logic [31:0]        mem [Depth];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         xor_q;
`endif

  logic               xfer;
  logic               word_done;
  logic               mem_we;
  logic               last_word;
  logic [LEN_W-1:0]   hdr_next;
  logic [31:0]        wdata;

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign in_ready = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    || (state_q == StChk)
`endif
                    ;

  assign xfer      = in_valid & in_ready;
  assign word_done = xfer && (state_q == StData) && (byte_cnt_q == 2'd3);
  // Past the end of the RAM words are consumed but dropped; rst discards the word too.
  assign mem_we    = word_done && !wptr_q[ADDR_W] && !rst;
  assign last_word = ((word_cnt_q + LenOne) == len_q);
  assign hdr_next  = LEN_W'({in_data, len_lo_q});
  assign wdata     = {in_data, word_buf_q};

  assign err          = err_q;
  assign words_loaded = words_loaded_q;
  assign rd_data      = rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      len_lo_q       <= '0;
      len_q          <= '0;
      byte_cnt_q     <= '0;
      word_buf_q     <= '0;
      wptr_q         <= '0;
      word_cnt_q     <= '0;
      words_loaded_q <= '0;
      err_q          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q          <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_start) begin
            state_q        <= StLenLo;
            byte_cnt_q     <= '0;
            wptr_q         <= '0;
            word_cnt_q     <= '0;
            words_loaded_q <= '0;
            err_q          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q          <= '0;
`endif
          end
        end
        StLenLo: begin
          if (xfer) begin
            len_lo_q <= in_data;
            state_q  <= StLenHi;
          end
        end
        StLenHi: begin
          if (xfer) begin
            len_q   <= hdr_next;
            state_q <= (hdr_next == '0) ? StEnd : StData;
          end
        end
        StData: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ in_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q <= '0;
              word_cnt_q <= word_cnt_q + LenOne;
              if (!wptr_q[ADDR_W]) begin
                wptr_q         <= wptr_q + WptrOne;
                words_loaded_q <= words_loaded_q + LenOne;
              end else begin
                err_q <= 1'b1;
              end
              if (last_word) state_q <= StEnd;
            end else begin
              unique case (byte_cnt_q)
                2'd0:    word_buf_q[7:0]   <= in_data;
                2'd1:    word_buf_q[15:8]  <= in_data;
                default: word_buf_q[23:16] <= in_data;
              endcase
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk: begin
          if (xfer) begin
            if (in_data != xor_q) err_q <= 1'b1;
            state_q <= StDone;
          end
        end
`endif
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[ADDR_W-1:0]] <= wdata;
  end

  // Read-before-write; fetch sees NOPs while a program is being loaded.
  always_ff @(posedge clk) begin
    if (rst || busy) rd_data_q <= '0;
    else             rd_data_q <= mem[rd_addr[ADDR_W+1:2]];
  end

  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int unsigned AW    = 2;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          load_start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] words_loaded;
  logic [31:0]   rd_addr;
  logic [31:0]   rd_data;

  imem_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int known = 0;                  // words 0..known-1 of the model are defined
  logic [31:0] mem_m [DEPTH];     // reference RAM image
  logic [7:0]  pl [$];            // payload of the session being driven

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // gap 0: back to back, 1: one idle cycle before each byte, 2: random 0..2 idle cycles
  task automatic send_gap(input int gap);
    int n;
    n = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start(input string tag);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check({tag, "_start_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_start_err"}, {31'b0, err}, 32'd0);
    check({tag, "_start_wl"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic verify_mem(input string tag);
    for (int a = 0; a < known; a++) begin
      // Random lane offset and upper bits must alias onto the same word.
      rd_addr = 32'(a * 4) + $urandom_range(0, 3) + 32'(DEPTH * 4) * $urandom_range(0, 7);
      tick();
      check($sformatf("%s_ram%0d", tag, a), rd_data, mem_m[a]);
    end
  endtask

  // Drives a whole session from pl[]; poke >= 0 pulses load_start after that many payload bytes.
  task automatic run_session(input int hdr, input int gap, input bit bad_chk, input int poke,
                             input string tag);
    logic [7:0] x;
    int exp_wl;
    bit exp_err;
    start(tag);
    send_gap(gap); send_byte(8'(hdr));
    send_gap(gap); send_byte(8'(hdr >> 8));
    x = 8'h00;
    for (int i = 0; i < pl.size(); i++) begin
      if (i == poke) begin
        load_start = 1'b1;
        rd_addr    = $urandom;
        tick();
        load_start = 1'b0;
        check({tag, "_poke_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_busy_rd"}, rd_data, 32'h0);
      end
      send_gap(gap);
      send_byte(pl[i]);
      x ^= pl[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_gap(gap);
    send_byte(bad_chk ? (x ^ 8'h80) : x);
`endif
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_rd_while_done"}, rd_data, 32'h0);
    tick();
    check({tag, "_done_off"}, {31'b0, done}, 32'd0);
    check({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
    check({tag, "_rdy_off"}, {31'b0, in_ready}, 32'd0);
    for (int w = 0; w < hdr && w < DEPTH; w++)
      mem_m[w] = {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]};
    exp_wl  = (hdr < DEPTH) ? hdr : DEPTH;
    exp_err = (hdr > DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = exp_err || bad_chk;
`endif
    if (exp_wl > known) known = exp_wl;
    check({tag, "_wl"}, 32'(words_loaded), 32'(exp_wl));
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    verify_mem(tag);
  endtask

  task automatic fill_random(input int nbytes);
    pl.delete();
    for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    logic [31:0] w0;
    int hdr;
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_addr = 32'h0;

    // Reset / idle
    tick(); tick();
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_wl", 32'(words_loaded), 32'd0);
    check("rst_rd", rd_data, 32'h0);
    rst = 1'b0;
    tick();

    // Basic load
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_session(2, 0, 1'b0, -1, "basic");
    rd_addr = 32'd4;
    tick();
    check("basic_rd4", rd_data, 32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_session(2, 0, 1'b1, -1, "badchk");
`endif

    // Fill the whole RAM, then reset and confirm the contents survive
    fill_random(16);
    run_session(4, 0, 1'b0, -1, "fill");
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    rd_addr = 32'd0;
    tick();
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_rd0", rd_data, mem_m[0]);

    // Gapped stream: in_valid low every other cycle
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_session(2, 1, 1'b0, -1, "gaps");

    // Zero length
    pl.delete();
    run_session(0, 0, 1'b0, -1, "zero");

    // Overflow: 5 words into a 4-word RAM; the next start must clear err
    fill_random(20);
    run_session(5, 0, 1'b0, -1, "ovf");

    // load_start during DATA is ignored
    fill_random(8);
    run_session(2, 0, 1'b0, 2, "ignore");

    // Reset after 6 data bytes: word 0 kept, word 1 untouched
    fill_random(6);
    start("midrst");
    send_byte(8'd3);
    send_byte(8'd0);
    for (int i = 0; i < 6; i++) send_byte(pl[i]);
    rd_addr = $urandom;
    tick();
    check("midrst_busy_rd", rd_data, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_wl", 32'(words_loaded), 32'd0);
    w0 = {pl[3], pl[2], pl[1], pl[0]};
    mem_m[0] = w0;
    verify_mem("midrst");

    // Randomized sessions
    for (int s = 0; s < 12; s++) begin
      hdr = int'($urandom_range(0, 6));
      fill_random(hdr * 4);
      run_session(hdr, 2, 1'($urandom_range(0, 1)),
                  (hdr > 0) ? int'($urandom_range(0, hdr * 4 - 1)) : -1,
                  $sformatf("rnd%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute guard so the bench cannot hang
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
